// File: rtl/tap_delay_pkg.sv
// Shared defaults and constant helpers for the tap delay line.
// Used by tap_delay_line and tap_delay_stage via import tap_delay_pkg::*.
package tap_delay_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 4;

   // Smallest n with 2**n >= value; usable in parameter defaults.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/tap_delay_stage.sv
// One WIDTH-bit delay stage: async reset, load enable and synchronous clear.
// Clear has priority over load so a flush always wins inside a stage.
module tap_delay_stage
   import tap_delay_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // NOTE: state is written with non-blocking assignments so every stage samples its neighbour's pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/tap_delay_line.sv
// Shift-register delay line with a selectable tap, valid flag and fill count.
// Build option: define TAP_DELAY_OUT_REG_EN to register dout/dout_valid (one extra cycle).
module tap_delay_line
   import tap_delay_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int SEL_W = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [SEL_W:0]   fill
);

   localparam int                FILL_W   = SEL_W + 1;
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
   localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

   logic [WIDTH-1:0]  w_stage [DEPTH];
   logic [WIDTH-1:0]  w_tap;
   logic              w_tap_valid;
   logic [FILL_W-1:0] r_fill;

   // Flush with en set is flush-then-load: the head keeps loading din, the rest clear.
   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [WIDTH-1:0] w_d;
      logic             w_clr;

      if (k == 0) begin : g_head
         assign w_d   = din;
         assign w_clr = flush & ~en;
      end else begin : g_body
         assign w_d   = w_stage[k-1];
         assign w_clr = flush;
      end

      tap_delay_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .i_en  (en),
         .i_clr (w_clr),
         .i_d   (w_d),
         .o_q   (w_stage[k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill <= '0;
      end else if (flush) begin
         r_fill <= en ? FILL_ONE : '0;
      end else if (en && (r_fill != FILL_MAX)) begin
         r_fill <= r_fill + FILL_ONE;
      end
   end

   // NOTE: w_tap gets a default before the search loop so no latch is inferred and out-of-range selects read zero.
   always_comb begin
      w_tap = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (sel == SEL_W'(k)) w_tap = w_stage[k];
      end
   end

   // fill never exceeds DEPTH, so this also rejects out-of-range selects.
   assign w_tap_valid = ({1'b0, sel} < r_fill);

`ifdef TAP_DELAY_OUT_REG_EN
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else if (flush) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_dout       <= w_tap;
         r_dout_valid <= w_tap_valid;
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
`else
   assign dout       = w_tap;
   assign dout_valid = w_tap_valid;
`endif

   assign fill = r_fill;

endmodule

// File: tb/tb_tap_delay_line.sv
// Scoreboard bench for tap_delay_line: a 4x8 instance and a 5x16 instance share control.
// Tap expectations are due LAT cycles after issue so the registered-output build is covered too.
module tb_tap_delay_line;

`ifdef TAP_DELAY_OUT_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      int          due;
      int          dut;
      logic [15:0] exp;
      logic        exp_valid;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        flush;
   logic [7:0]  din_a;
   logic [15:0] din_b;
   logic [1:0]  sel_a;
   logic [2:0]  sel_b;
   logic [7:0]  dout_a;
   logic [15:0] dout_b;
   logic        valid_a;
   logic        valid_b;
   logic [2:0]  fill_a;
   logic [3:0]  fill_b;

   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t q_tap[$];
   exp_t q_fill[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tap_delay_line #(.WIDTH(8), .DEPTH(4)) u_dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .flush      (flush),
      .din        (din_a),
      .sel        (sel_a),
      .dout       (dout_a),
      .dout_valid (valid_a),
      .fill       (fill_a)
   );

   tap_delay_line #(.WIDTH(16), .DEPTH(5)) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .flush      (flush),
      .din        (din_b),
      .sel        (sel_b),
      .dout       (dout_b),
      .dout_valid (valid_b),
      .fill       (fill_b)
   );

   // Monitor: pops whatever is due this cycle and compares away from the rising edge.
   initial begin
      exp_t        m_it;
      logic [15:0] m_act;
      logic        m_v;
      forever begin
         @(negedge clk);
         while (q_fill.size() != 0 && q_fill[0].due <= cyc) begin
            m_it  = q_fill.pop_front();
            m_act = (m_it.dut == 0) ? 16'(fill_a) : 16'(fill_b);
            n_cmp++;
            if (m_act !== m_it.exp) begin
               n_fail++;
               $display("FAIL %s: fill got %0d expected %0d", m_it.name, m_act, m_it.exp);
            end
         end
         while (q_tap.size() != 0 && q_tap[0].due <= cyc) begin
            m_it  = q_tap.pop_front();
            m_act = (m_it.dut == 0) ? 16'(dout_a) : dout_b;
            m_v   = (m_it.dut == 0) ? valid_a : valid_b;
            n_cmp++;
            if (m_act !== m_it.exp || m_v !== m_it.exp_valid) begin
               n_fail++;
               $display("FAIL %s: dout=%h valid=%b expected dout=%h valid=%b",
                        m_it.name, m_act, m_v, m_it.exp, m_it.exp_valid);
            end
         end
      end
   end

   task automatic step(input logic e, input logic f, input logic [7:0] d);
      en    = e;
      flush = f;
      din_a = d;
      din_b = {d, d};
      @(posedge clk);
      #1;
   endtask

   task automatic check_fill(input int dut, input int e, input string nm);
      exp_t it;
      it.due       = cyc;
      it.dut       = dut;
      it.exp       = 16'(e);
      it.exp_valid = 1'b0;
      it.name      = nm;
      q_fill.push_back(it);
   endtask

   // Holds the line for one cycle with the new select; imm checks the current cycle only.
   task automatic check_tap(input int dut, input int s, input logic [15:0] e, input logic v,
                            input string nm, input bit imm = 1'b0);
      exp_t it;
      if (dut == 0) sel_a = s[1:0];
      else          sel_b = s[2:0];
      en           = 1'b0;
      flush        = 1'b0;
      it.due       = imm ? cyc : cyc + LAT;
      it.dut       = dut;
      it.exp       = e;
      it.exp_valid = v;
      it.name      = nm;
      q_tap.push_back(it);
      if (!imm) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      flush = 1'b0;
      din_a = '0;
      din_b = '0;
      sel_a = '0;
      sel_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check_fill(0, 0, "reset_fill_a");
      check_fill(1, 0, "reset_fill_b");
      check_tap(0, 0, 16'h0000, 1'b0, "reset_tap_a");
      rst_n = 1'b1;

      // Fill from empty
      step(1'b1, 1'b0, 8'h11); check_fill(0, 1, "fill_1");
      step(1'b1, 1'b0, 8'h22); check_fill(0, 2, "fill_2");
      step(1'b1, 1'b0, 8'h33); check_fill(0, 3, "fill_3");
      step(1'b1, 1'b0, 8'h44); check_fill(0, 4, "fill_4");
      check_fill(1, 4, "fill_b_4");
      check_tap(0, 3, 16'h0011, 1'b1, "full_sel3");
      check_tap(0, 0, 16'h0044, 1'b1, "full_sel0");
      check_tap(0, 1, 16'h0033, 1'b1, "full_sel1");
      check_tap(0, 2, 16'h0022, 1'b1, "full_sel2");
      check_tap(1, 3, 16'h1111, 1'b1, "b_sel3");
      check_tap(1, 4, 16'h0000, 1'b0, "b_sel4_unfilled");
      check_tap(1, 6, 16'h0000, 1'b0, "b_sel6_range");

      // Hold, then saturate
      repeat (5) step(1'b0, 1'b0, 8'hFF);
      check_fill(0, 4, "hold_fill");
      check_tap(0, 0, 16'h0044, 1'b1, "hold_sel0");
      check_tap(0, 3, 16'h0011, 1'b1, "hold_sel3");
      step(1'b1, 1'b0, 8'h55);
      check_fill(0, 4, "sat_fill_1");
      check_fill(1, 5, "sat_fill_b_1");
      step(1'b1, 1'b0, 8'h66);
      step(1'b1, 1'b0, 8'h77);
      check_fill(0, 4, "sat_fill_3");
      check_fill(1, 5, "sat_fill_b_3");
      check_tap(0, 0, 16'h0077, 1'b1, "sat_sel0");
      check_tap(0, 3, 16'h0044, 1'b1, "sat_sel3");
      check_tap(1, 4, 16'h3333, 1'b1, "b_sat_sel4");
      check_tap(1, 5, 16'h0000, 1'b0, "b_sel5_range");
      check_tap(1, 6, 16'h0000, 1'b0, "b_sel6_full");

      // Flush collisions
      step(1'b1, 1'b1, 8'h5A);
      check_fill(0, 1, "flush_load_fill");
      check_fill(1, 1, "flush_load_fill_b");
      check_tap(0, 0, 16'h005A, 1'b1, "flush_load_sel0");
      check_tap(0, 1, 16'h0000, 1'b0, "flush_load_sel1");
      check_tap(0, 2, 16'h0000, 1'b0, "flush_load_sel2");
      check_tap(0, 3, 16'h0000, 1'b0, "flush_load_sel3");
      check_tap(1, 0, 16'h5A5A, 1'b1, "b_flush_load_sel0");
      step(1'b0, 1'b1, 8'h00);
      check_fill(0, 0, "flush_only_fill");
      check_fill(1, 0, "flush_only_fill_b");
      check_tap(0, 0, 16'h0000, 1'b0, "flush_only_sel0");

      // Partial fill
      step(1'b1, 1'b0, 8'hA1);
      step(1'b1, 1'b0, 8'hA2);
      check_fill(0, 2, "partial_fill");
      check_tap(0, 2, 16'h0000, 1'b0, "partial_sel2");
      check_tap(0, 1, 16'h00A1, 1'b1, "partial_sel1");
      check_tap(0, 0, 16'h00A2, 1'b1, "partial_sel0");
      check_tap(1, 1, 16'hA1A1, 1'b1, "b_partial_sel1");

      // Async reset between edges
      step(1'b1, 1'b0, 8'hB3);
      check_fill(0, 3, "pre_reset_fill");
      step(1'b0, 1'b0, 8'h00);
      #1;
      rst_n = 1'b0;
      check_fill(0, 0, "async_rst_fill");
      check_fill(1, 0, "async_rst_fill_b");
      check_tap(0, 0, 16'h0000, 1'b0, "async_rst_tap", 1'b1);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 8'h7E);
      check_fill(0, 1, "post_rst_fill");
      check_tap(0, 0, 16'h007E, 1'b1, "post_rst_sel0");
      check_tap(0, 1, 16'h0000, 1'b0, "post_rst_no_history");

      repeat (3) @(posedge clk);
      #1;
      if (q_tap.size() != 0 || q_fill.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d tap and %0d fill expectations never checked",
                  q_tap.size(), q_fill.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tap_delay_line.md
TAP_DELAY_LINE -- requirements
Module: tap_delay_line

Interface
REQ-001 Parameter WIDTH, default 8: sample width in bits, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4: number of delay stages, SHALL be >= 2, and need not be a power of two.
REQ-003 Parameter SEL_W, default $clog2(DEPTH): tap-select width, SHALL be derived from DEPTH and never overridden.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  shift enable; stages advance only when high.
REQ-007 flush  input  1  synchronous clear of stage contents and fill count.
REQ-008 din  input  WIDTH  sample shifted into stage 0.
REQ-009 sel  input  SEL_W  tap select; tap k is the sample delayed by k accepted shifts.
REQ-010 dout  output  WIDTH  selected tap value.
REQ-011 dout_valid  output  1  high when the selected tap holds a sample written since reset or flush.
REQ-012 fill  output  SEL_W+1  count of valid stages, saturating at DEPTH.

Function
REQ-013 With en=1, stage[0] SHALL take din and stage[k] SHALL take stage[k-1] for k=1..DEPTH-1 on the same edge.
REQ-014 With en=0 and flush=0, all stages and fill SHALL hold.
REQ-015 fill SHALL increment by 1 on each edge with en=1, saturating at DEPTH and never wrapping.
REQ-016 dout SHALL equal stage[sel] combinationally, with zero added latency in the base build.
REQ-017 dout_valid SHALL equal (sel < fill).
REQ-018 If sel >= DEPTH (possible only for non-power-of-two DEPTH), dout SHALL be all zeros and dout_valid SHALL be 0.
REQ-019 With flush=1 and en=0, all stages SHALL clear to 0 and fill SHALL clear to 0 on the next edge.
REQ-020 With flush=1 and en=1, stage[0] SHALL take din, stages 1..DEPTH-1 SHALL clear to 0, and fill SHALL become 1 (flush-then-load).
REQ-021 A change on sel SHALL affect dout and dout_valid in the same cycle, with no state change.

Reset
REQ-022 rst_n low SHALL immediately clear all stages to 0 and fill to 0, independent of clk.
REQ-023 During reset, dout SHALL be 0 and dout_valid SHALL be 0.
REQ-024 After rst_n deasserts, the first en=1 edge SHALL load din into stage[0] and set fill to 1.
REQ-025 Reset asserted mid-fill SHALL discard all history, and no partial fill SHALL survive.

Configuration
REQ-026 Macro TAP_DELAY_OUT_REG_EN.
- Defined: dout and dout_valid SHALL be registered, giving one added cycle of latency from stage/sel to output; the output register SHALL reset to 0 asynchronously and SHALL clear on flush.
- Undefined: outputs are combinational per REQ-016 and REQ-017.

Structure
REQ-027 A shared package tap_delay_pkg SHALL hold the WIDTH/DEPTH defaults and a clog2 helper constant function.
REQ-028 One sub-module tap_delay_stage SHALL be used: a single WIDTH-bit register with async reset, enable and synchronous clear, instantiated DEPTH times via generate.
REQ-029 Tap mux and fill counter SHALL reside in tap_delay_line.

Verification
REQ-030 Reset then fill: DEPTH=4, en=1, din=0x11,0x22,0x33,0x44 on successive cycles -> fill reaches 1,2,3,4; sel=3 gives dout=0x11, valid=1; sel=0 gives 0x44.
REQ-031 Partial fill: after two shifts (0xA1,0xA2), sel=2 -> dout_valid=0; sel=1 -> dout=0xA1, valid=1.
REQ-032 Hold and saturate: full line, en=0 for 5 cycles -> all taps unchanged; then 3 more shifts -> fill stays 4.
REQ-033 Flush collisions: full line, flush=1, en=1, din=0x5A -> next cycle fill=1, tap0=0x5A, taps 1-3=0; flush=1, en=0 -> fill=0, all dout_valid=0.
REQ-034 Async reset mid-operation: rst_n low between edges -> dout=0 and fill=0 immediately; after release, one shift of 0x7E gives fill=1, sel=0 dout=0x7E.
REQ-035 DEPTH=5, WIDTH=16, with TAP_DELAY_OUT_REG_EN defined: sel=6 -> dout=0, valid=0; tap changes appear on dout one cycle after the combinational build.
